calc1_port_driver: RTL and testbench

Upstream request driver for one calc1_top port; one instance per port, four total. It buffers complete requests (command, two operands, tag) in a small FIFO and drives the calc1 two-cycle request protocol on that port's `reqN_cmd_in`/`reqN_data_in`. It keeps at most one command outstanding, captures the matching `out_respN`/`out_dataN`, and returns the result over a valid/ready interface. A watchdog converts missing responses into timeout results.

---
 rtl/calc1_port_driver.sv | 172 +++++++++++++++++
 tb/tb_calc1_port_driver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/calc1_port_driver.sv
// Per-port request driver for calc1_top: queues complete requests, drives the
// two-cycle calc1 request protocol, and returns one result at a time with a watchdog.
module calc1_port_driver #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 20
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_op,
  input  logic [31:0] cmd_data1,
  input  logic [31:0] cmd_data2,
  input  logic [1:0]  cmd_tag,
  output logic [3:0]  req_cmd_out,
  output logic [31:0] req_data_out,
  input  logic [1:0]  out_resp,
  input  logic [31:0] out_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [1:0]  rsp_resp,
  output logic [31:0] rsp_data,
  output logic [1:0]  rsp_tag,
  output logic        rsp_timeout,
  output logic        stray_resp,
  output logic        busy
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
  localparam logic [WW-1:0] WD_LAST  = WW'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SEND1 = 2'd1;
  localparam logic [1:0] SEND2 = 2'd2;
  localparam logic [1:0] WAIT  = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [69:0]   fifo_mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          push, pop;
  logic [69:0]   head;
  logic [31:0]   iss_data2;
  logic [1:0]    iss_tag;
  logic [WW-1:0] wd_cnt;
  logic          resp_seen, capture, timeout_hit;

  assign cmd_ready = (count != FULL_CNT);
  assign push      = cmd_valid && cmd_ready;
  // Issue only from IDLE with the result slot free: one command outstanding at most.
  assign pop       = (state == IDLE) && (count != '0) && !rsp_valid;
  assign head      = fifo_mem[rd_ptr];
  assign resp_seen = (out_resp != 2'b00);

  always_comb begin
    count_nxt = count;
    if (push && !pop)
      count_nxt = count + CW'(1);
    else if (pop && !push)
      count_nxt = count - CW'(1);
  end

  always_comb begin
    state_nxt   = state;
    capture     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE:  if (pop) state_nxt = SEND1;
      SEND1: state_nxt = SEND2;
      SEND2: begin
        if (resp_seen) begin
          state_nxt = IDLE;
          capture   = 1'b1;
        end else begin
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (resp_seen) begin
          state_nxt = IDLE;
          capture   = 1'b1;
        end else if (wd_cnt == WD_LAST) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge c_clk) begin
    if (push)
      fifo_mem[wr_ptr] <= {cmd_op, cmd_data1, cmd_data2, cmd_tag};
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge c_clk) begin
    if (reset) begin
      state        <= IDLE;
      req_cmd_out  <= '0;
      req_data_out <= '0;
      iss_data2    <= '0;
      iss_tag      <= '0;
      wd_cnt       <= '0;
      rsp_valid    <= 1'b0;
      rsp_resp     <= '0;
      rsp_data     <= '0;
      rsp_tag      <= '0;
      rsp_timeout  <= 1'b0;
      stray_resp   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state      <= state_nxt;
      stray_resp <= resp_seen && ((state == IDLE) || (state == SEND1));
      busy       <= (state_nxt != IDLE) || (count_nxt != '0);

      // Bus registers follow the next state so each phase is visible in its own cycle.
      if (pop) begin
        req_cmd_out  <= head[69:66];
        req_data_out <= head[65:34];
        iss_data2    <= head[33:2];
        iss_tag      <= head[1:0];
      end else if (state == SEND1) begin
        req_cmd_out  <= '0;
        req_data_out <= iss_data2;
      end else begin
        req_cmd_out  <= '0;
        req_data_out <= '0;
      end

      if (state == SEND2)
        wd_cnt <= '0;
      else if ((state == WAIT) && !resp_seen)
        wd_cnt <= wd_cnt + WW'(1);

      if (capture) begin
        rsp_valid   <= 1'b1;
        rsp_resp    <= out_resp;
        rsp_data    <= out_data;
        rsp_tag     <= iss_tag;
        rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        rsp_valid   <= 1'b1;
        rsp_resp    <= '0;
        rsp_data    <= '0;
        rsp_tag     <= iss_tag;
        rsp_timeout <= 1'b1;
      end else if (rsp_valid && rsp_ready) begin
        rsp_valid   <= 1'b0;
        rsp_resp    <= '0;
        rsp_data    <= '0;
        rsp_tag     <= '0;
        rsp_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_calc1_port_driver.sv
// Directed bench for calc1_port_driver: the bench plays calc1 on the response side
// and checks bus phases, result capture, timeout, stray responses and reset.
module tb_calc1_port_driver;

  logic        c_clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_data1, cmd_data2;
  logic [1:0]  cmd_tag;
  logic [3:0]  req_cmd_out;
  logic [31:0] req_data_out;
  logic [1:0]  out_resp;
  logic [31:0] out_data;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_resp;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_tag;
  logic        rsp_timeout, stray_resp, busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n, accepted, send1_cnt;
  bit prev_send1;

  calc1_port_driver #(.FIFO_DEPTH(4), .TIMEOUT(20)) dut (
    .c_clk(c_clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data1(cmd_data1), .cmd_data2(cmd_data2), .cmd_tag(cmd_tag),
    .req_cmd_out(req_cmd_out), .req_data_out(req_data_out),
    .out_resp(out_resp), .out_data(out_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp),
    .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
    .stray_resp(stray_resp), .busy(busy)
  );

  always #5 c_clk = ~c_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge c_clk);
    #1;
  endtask

  task automatic push_req(input logic [3:0] op, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [1:0] tag);
    cmd_op = op; cmd_data1 = d1; cmd_data2 = d2; cmd_tag = tag;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_data1 = '0; cmd_data2 = '0;
    cmd_tag = '0; out_resp = '0; out_data = '0; rsp_ready = 1'b0;
    step(); step();
    check("rst_req_cmd", 32'(req_cmd_out), 0);
    check("rst_req_data", req_data_out, 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_resp", 32'(rsp_resp), 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_tag", 32'(rsp_tag), 0);
    check("rst_rsp_timeout", 32'(rsp_timeout), 0);
    check("rst_stray", 32'(stray_resp), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_cmd_ready", 32'(cmd_ready), 1);
    reset = 1'b0;

    // Add request answered during SEND2
    push_req(4'h1, 32'h80002345, 32'h00010000, 2'd2);
    check("add_busy", 32'(busy), 1);
    step();
    check("add_s1_cmd", 32'(req_cmd_out), 1);
    check("add_s1_data", req_data_out, 32'h80002345);
    step();
    check("add_s2_cmd", 32'(req_cmd_out), 0);
    check("add_s2_data", req_data_out, 32'h00010000);
    out_resp = 2'b01; out_data = 32'h80012345;
    step();
    out_resp = 2'b00; out_data = '0;
    check("add_rsp_valid", 32'(rsp_valid), 1);
    check("add_rsp_resp", 32'(rsp_resp), 1);
    check("add_rsp_data", rsp_data, 32'h80012345);
    check("add_rsp_tag", 32'(rsp_tag), 2);
    check("add_rsp_timeout", 32'(rsp_timeout), 0);
    check("add_idle_busy", 32'(busy), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("add_hs_valid", 32'(rsp_valid), 0);
    check("add_hs_data", rsp_data, 0);

    // Invalid opcode answered while waiting
    push_req(4'h3, 32'h1, 32'h1, 2'd1);
    step();
    check("inv_s1_cmd", 32'(req_cmd_out), 3);
    step(); step(); step();
    check("inv_wait_valid", 32'(rsp_valid), 0);
    out_resp = 2'b10; out_data = 32'h0;
    step();
    out_resp = 2'b00;
    check("inv_rsp_valid", 32'(rsp_valid), 1);
    check("inv_rsp_resp", 32'(rsp_resp), 2);
    check("inv_rsp_timeout", 32'(rsp_timeout), 0);
    check("inv_rsp_tag", 32'(rsp_tag), 1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Opcode 0000 never answered: watchdog completes it
    push_req(4'h0, 32'h11, 32'h22, 2'd3);
    step();
    check("to_s1_data", req_data_out, 32'h11);
    step();
    check("to_s2_data", req_data_out, 32'h22);
    n = 0;
    while (!rsp_valid && n < 30) begin
      step();
      n++;
    end
    check("to_latency", 32'(n), 21);
    check("to_rsp_resp", 32'(rsp_resp), 0);
    check("to_rsp_data", rsp_data, 0);
    check("to_rsp_timeout", 32'(rsp_timeout), 1);
    check("to_rsp_tag", 32'(rsp_tag), 3);

    // Late response while IDLE, with a request queued behind the handshake
    rsp_ready = 1'b1;
    cmd_op = 4'h1; cmd_data1 = 32'h5; cmd_data2 = 32'h6; cmd_tag = 2'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    check("late_hs_valid", 32'(rsp_valid), 0);
    out_resp = 2'b01; out_data = 32'hDEAD;
    step();
    out_resp = 2'b00; out_data = '0;
    check("late_stray", 32'(stray_resp), 1);
    check("late_rsp_valid", 32'(rsp_valid), 0);
    check("late_s1_cmd", 32'(req_cmd_out), 1);
    check("late_s1_data", req_data_out, 32'h5);
    step();
    check("late_stray_once", 32'(stray_resp), 0);
    check("late_s2_data", req_data_out, 32'h6);
    out_resp = 2'b01; out_data = 32'hB;
    step();
    out_resp = 2'b00; out_data = '0;
    check("late_rsp_valid2", 32'(rsp_valid), 1);
    check("late_rsp_data", rsp_data, 32'hB);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;

    // Back-pressure: continuous pushes, result never consumed
    accepted = 0; send1_cnt = 0; prev_send1 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (req_cmd_out != 4'h0) send1_cnt++;
      out_resp = prev_send1 ? 2'b01 : 2'b00;
      out_data = prev_send1 ? 32'hCAFE0001 : 32'h0;
      prev_send1 = (req_cmd_out != 4'h0);
      if (cmd_ready) begin
        cmd_op = 4'h1; cmd_data1 = 32'h1000 + 32'(accepted);
        cmd_data2 = 32'h2000 + 32'(accepted); cmd_tag = 2'(accepted);
        cmd_valid = 1'b1;
        accepted++;
      end else begin
        cmd_valid = 1'b0;
      end
      step();
    end
    cmd_valid = 1'b0; out_resp = 2'b00; out_data = '0;
    check("bp_accepted", 32'(accepted), 5);
    check("bp_send1_cnt", 32'(send1_cnt), 1);
    check("bp_cmd_ready", 32'(cmd_ready), 0);
    check("bp_rsp_valid", 32'(rsp_valid), 1);
    check("bp_rsp_resp", 32'(rsp_resp), 1);
    check("bp_rsp_data", rsp_data, 32'hCAFE0001);
    check("bp_rsp_tag", 32'(rsp_tag), 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("bp_hs_valid", 32'(rsp_valid), 0);
    check("bp_full_pop_ready", 32'(cmd_ready), 0);
    step();
    check("bp_ready_rise", 32'(cmd_ready), 1);
    check("bp_next_s1_cmd", 32'(req_cmd_out), 1);
    check("bp_next_s1_data", req_data_out, 32'h1001);
    step();
    check("bp_next_s2_data", req_data_out, 32'h2001);
    step();
    check("wait_busy", 32'(busy), 1);

    // Reset in WAIT with three entries still queued
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mrst_req_cmd", 32'(req_cmd_out), 0);
    check("mrst_req_data", req_data_out, 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_cmd_ready", 32'(cmd_ready), 1);
    check("mrst_rsp_valid", 32'(rsp_valid), 0);
    push_req(4'h1, 32'h7, 32'h8, 2'd2);
    step();
    check("prst_s1_cmd", 32'(req_cmd_out), 1);
    check("prst_s1_data", req_data_out, 32'h7);
    step();
    check("prst_s2_data", req_data_out, 32'h8);
    out_resp = 2'b01; out_data = 32'hF;
    step();
    out_resp = 2'b00; out_data = '0;
    check("prst_rsp_data", rsp_data, 32'hF);
    check("prst_rsp_tag", 32'(rsp_tag), 2);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step(); step(); step();
    check("prst_drained_busy", 32'(busy), 0);
    check("prst_drained_cmd", 32'(req_cmd_out), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
